exec_unit_pipe: RTL and testbench
=================================

// Module: exec_unit_pipe
// PURPOSE
//  Parametrised, clocked successor to the combinational execution unit.
//  Holds a DATA_W x 2**ADDR_W register file and accepts one instruction per cycle
//  (opcode, src addr1/addr2, dst addr3, imm) over a valid/ready handshake.
//  Executes the instruction in a 2-stage pipeline (request reg -> execute/writeback)
//  and presents result, operands and flags with output backpressure.
// PARAMETERS
//  DATA_W  8  operand/result/register width (>=4)
//  ADDR_W  5  register address width; register file depth = 2**ADDR_W
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       instruction present
//  in_ready   out  1       instruction accepted when in_valid && in_ready
//  opcode     in   4       operation (see BEHAVIOUR)
//  addr1      in   ADDR_W  source A register
//  addr2      in   ADDR_W  source B register
//  addr3      in   ADDR_W  destination register
//  imm        in   DATA_W  immediate, used by LDI only
//  out_valid  out  1       result present
//  out_ready  in   1       result consumed when out_valid && out_ready
//  a, b       out  DATA_W  operand values used by the presented result
//  out        out  DATA_W  result
//  flag       out  4       {V,N,C,Z}
// BEHAVIOUR
//  - Reset: rf[*]=0, request stage empty, out_valid=0, a=b=out=0, flag=0, in_ready=1.
//  - Stage D: a handshake captures opcode/addr1/addr2/addr3/imm.
//    in_ready = !d_valid || d_advance.
//  - d_advance = d_valid && (!out_valid || out_ready) && op_done; op_done=1 except MUL.
//  - On d_advance: read rf[addr1], rf[addr2]; compute; write rf[addr3] at the same edge;
//    load a/b/out/flag; out_valid=1.
//    A later instruction therefore always reads up-to-date values; no hazard logic exists.
//  - Latency: accept at edge k -> out_valid from edge k+1. Throughput 1/cycle when out_ready=1.
//  - out_valid && !out_ready: a/b/out/flag are held stable and stage D stalls.
//    No result is lost or duplicated.
//  - Opcodes:
//    - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a
//    - 6 SHL a by 1, 7 SHR a (logical) by 1
//    - 8 INC a, 9 DEC a
//    - A LDI: out=imm
//    - B CMP: a-b, flags only, no rf write
//    - C MUL (optional)
//    - D-F NOP: no rf write, out=0, flags hold
//  - Flags (updated on every op except NOP):
//    - Z = (out==0).
//    - C = carry-out (ADD/INC); borrow (SUB/DEC/CMP); shifted-out bit (SHL/SHR); 0 otherwise.
//    - N = out[DATA_W-1].
//    - V = signed overflow for ADD/SUB/CMP/INC/DEC; 0 otherwise.
//  - Arithmetic is modulo 2**DATA_W; wrap-around is silent except for the flags.
//  - Writes to addr3 == addr1 use the old value as the operand (read-before-write).
//  - rst_n asserted at any time, including mid-MUL or while stalled:
//    all state clears immediately, and the pending instruction is discarded.
// CONFIGURATION
//  - Macro EXEC_UNIT_MUL_EN.
//  - Defined: opcode C = iterative shift-add multiply, one bit per cycle.
//    - D holds for DATA_W cycles; in_ready=0 meanwhile.
//    - out = low DATA_W bits, written to rf[addr3].
//    - C = (high half != 0); Z and N from out; V=0.
//    - Result is valid at edge k+1+DATA_W.
//  - Undefined: opcode C behaves as NOP; no multiplier logic is synthesised.
// STRUCTURE
//  - Package exec_unit_pkg: opcode localparams (OP_ADD..OP_NOP) and flag bit indices
//    (FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3).
//  - One sub-module, eu_iter_mul: start/done handshake, DATA_W-cycle counter and
//    accumulator, async reset. Instantiated only under EXEC_UNIT_MUL_EN.
//  - ALU and flag logic stay inline as combinational always blocks.
// TESTING (DATA_W=8, ADDR_W=5)
//  1. Reset -> out_valid=0, out=0, flag=0, in_ready=1;
//     ADD r3=r1+r2 -> out=0x00, flag=0001.
//  2. Back-to-back LDI r1=0x7F, LDI r2=0x01, ADD r3=r1+r2, out_ready=1
//     -> third result a=7F, b=01, out=0x80, flag=1100, one result per cycle.
//  3. SUB r4=r2-r1 -> out=0x82, flag=0110 (N,C=borrow);
//     CMP r1,r1 -> out=0x00, flag=0001, r1 unchanged.
//  4. out_ready=0 for 3 cycles with 2 instructions issued
//     -> out/flag held, in_ready=0 once D full, both results then delivered in order.
//  5. EXEC_UNIT_MUL_EN: LDI r1=0x10, r2=0x11, MUL r5 -> out=0x10, C=1, valid 9 cycles
//     after accept, in_ready=0 throughout. Macro off: flags unchanged, rf[5] unchanged.
//  6. rst_n pulsed low mid-MUL -> outputs 0 asynchronously;
//     afterwards ADD r6=r1+r2 -> out=0x00, flag=0001 (rf cleared).

Source files
------------

// File: rtl/exec_unit_pkg.sv
// rtl/exec_unit_pkg.sv - opcode encodings and flag bit positions for exec_unit_pipe
package exec_unit_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_NOP = 4'hD;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/eu_iter_mul.sv
// rtl/eu_iter_mul.sv - iterative shift-add multiplier, one multiplier bit per cycle
module eu_iter_mul #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ack,
  input  logic [DATA_W-1:0]     mcand,
  input  logic [DATA_W-1:0]     mplier,
  output logic                  done,
  output logic [2*DATA_W-1:0]   prod
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic                busy;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mc;
  logic [DATA_W-1:0]   mp;

  // Bit 0 is folded into the start edge so the product lands after DATA_W edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      mc   <= '0;
      mp   <= '0;
      prod <= '0;
    end else if (ack) begin
      done <= 1'b0;
    end else if (busy) begin
      if (mp[0]) prod <= prod + mc;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(DATA_W - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else if (start && !done) begin
      prod <= mplier[0] ? {{DATA_W{1'b0}}, mcand} : '0;
      mc   <= {{(DATA_W-1){1'b0}}, mcand, 1'b0};
      mp   <= mplier >> 1;
      cnt  <= CNT_W'(1);
      busy <= 1'b1;
    end
  end
endmodule

// File: rtl/exec_unit_pipe.sv
// rtl/exec_unit_pipe.sv - two-stage pipelined execution unit with register file
// Optional iterative multiply on opcode C when EXEC_UNIT_MUL_EN is defined.
module exec_unit_pipe
  import exec_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out,
  output logic [3:0]        flag
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int MSB   = DATA_W - 1;

  logic [DATA_W-1:0] rf [DEPTH];

  logic              d_valid;
  logic [3:0]        d_op;
  logic [ADDR_W-1:0] d_a1, d_a2, d_a3;
  logic [DATA_W-1:0] d_imm;

  logic              d_advance, op_done, accept;
  logic [DATA_W-1:0] src_a, src_b, res;
  logic [DATA_W:0]   sum;
  logic              c_res, v_res, wr_en, upd_flags;
  logic [3:0]        flag_nx;

  assign src_a     = rf[d_a1];
  assign src_b     = rf[d_a2];
  assign d_advance = d_valid && (!out_valid || out_ready) && op_done;
  assign in_ready  = !d_valid || d_advance;
  assign accept    = in_valid && in_ready;

`ifdef EXEC_UNIT_MUL_EN
  logic                is_mul, mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  assign is_mul  = d_valid && (d_op == OP_MUL);
  assign op_done = !is_mul || mul_done;

  eu_iter_mul #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (is_mul),
    .ack    (d_advance && is_mul),
    .mcand  (src_a),
    .mplier (src_b),
    .done   (mul_done),
    .prod   (mul_prod)
  );
`else
  assign op_done = 1'b1;
`endif

  always_comb begin
    sum       = '0;
    res       = '0;
    c_res     = 1'b0;
    v_res     = 1'b0;
    wr_en     = 1'b1;
    upd_flags = 1'b1;
    case (d_op)
      OP_ADD: begin
        sum   = {1'b0, src_a} + {1'b0, src_b};
        res   = sum[MSB:0];
        c_res = sum[DATA_W];
        v_res = (src_a[MSB] == src_b[MSB]) && (res[MSB] != src_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        sum   = {1'b0, src_a} - {1'b0, src_b};
        res   = sum[MSB:0];
        c_res = sum[DATA_W];
        v_res = (src_a[MSB] != src_b[MSB]) && (res[MSB] != src_a[MSB]);
        wr_en = (d_op == OP_SUB);
      end
      OP_AND: res = src_a & src_b;
      OP_OR:  res = src_a | src_b;
      OP_XOR: res = src_a ^ src_b;
      OP_NOT: res = ~src_a;
      OP_SHL: begin
        res   = {src_a[MSB-1:0], 1'b0};
        c_res = src_a[MSB];
      end
      OP_SHR: begin
        res   = {1'b0, src_a[MSB:1]};
        c_res = src_a[0];
      end
      OP_INC: begin
        sum   = {1'b0, src_a} + (DATA_W+1)'(1);
        res   = sum[MSB:0];
        c_res = sum[DATA_W];
        v_res = !src_a[MSB] && res[MSB];
      end
      OP_DEC: begin
        sum   = {1'b0, src_a} - (DATA_W+1)'(1);
        res   = sum[MSB:0];
        c_res = sum[DATA_W];
        v_res = src_a[MSB] && !res[MSB];
      end
      OP_LDI: res = d_imm;
`ifdef EXEC_UNIT_MUL_EN
      OP_MUL: begin
        res   = mul_prod[MSB:0];
        c_res = |mul_prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: begin
        wr_en     = 1'b0;
        upd_flags = 1'b0;
      end
    endcase
  end

  always_comb begin
    flag_nx         = '0;
    flag_nx[FLAG_Z] = (res == '0);
    flag_nx[FLAG_C] = c_res;
    flag_nx[FLAG_N] = res[MSB];
    flag_nx[FLAG_V] = v_res;
  end

  // Register file is written on the same edge the operands are consumed, so no hazards arise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      d_valid   <= 1'b0;
      d_op      <= '0;
      d_a1      <= '0;
      d_a2      <= '0;
      d_a3      <= '0;
      d_imm     <= '0;
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      out       <= '0;
      flag      <= '0;
    end else begin
      if (accept) begin
        d_valid <= 1'b1;
        d_op    <= opcode;
        d_a1    <= addr1;
        d_a2    <= addr2;
        d_a3    <= addr3;
        d_imm   <= imm;
      end else if (d_advance) begin
        d_valid <= 1'b0;
      end

      if (d_advance) begin
        out_valid <= 1'b1;
        a         <= src_a;
        b         <= src_b;
        out       <= res;
        if (upd_flags) flag <= flag_nx;
        if (wr_en) rf[d_a3] <= res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exec_unit_pipe.sv
// tb/tb_exec_unit_pipe.sv - directed self-checking bench for exec_unit_pipe (EXEC_UNIT_MUL_EN aware)
module tb_exec_unit_pipe;
  import exec_unit_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    opcode, flag;
  logic [AW-1:0] addr1, addr2, addr3;
  logic [DW-1:0] imm, a, b, out;

  int n_checks = 0;
  int n_errors = 0;

  exec_unit_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .addr1     (addr1),
    .addr2     (addr2),
    .addr3     (addr3),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .out       (out),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [AW-1:0] x1, x2, x3, input logic [DW-1:0] im);
    opcode   = op;
    addr1    = x1;
    addr2    = x2;
    addr3    = x3;
    imm      = im;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] x1, x2, x3, input logic [DW-1:0] im);
    int budget;
    budget = 0;
    @(negedge clk);
    drive(op, x1, x2, x3, im);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check_eq("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [DW-1:0] ea, eb, eo, input logic [3:0] ef);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!out_valid) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_a"}, a, ea);
      check_eq({tag, "_b"}, b, eb);
      check_eq({tag, "_out"}, out, eo);
      check_eq({tag, "_flag"}, flag, ef);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [AW-1:0] x1, x2, x3,
                     input logic [DW-1:0] im, ea, eb, eo, input logic [3:0] ef);
    issue(op, x1, x2, x3, im);
    expect_res(tag, ea, eb, eo, ef);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; addr1 = '0; addr2 = '0; addr3 = '0; imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out", out, 8'h00);
    check_eq("rst_flag", flag, 4'b0000);
    check_eq("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // 1: zeroed register file
    run("t1_add", OP_ADD, 5'd1, 5'd2, 5'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);

    // 2: back-to-back, one result per cycle
    @(negedge clk);
    drive(OP_LDI, 5'd0, 5'd0, 5'd1, 8'h7F);
    check_eq("t2_rdy0", in_ready, 1'b1);
    @(negedge clk);
    drive(OP_LDI, 5'd0, 5'd0, 5'd2, 8'h01);
    check_eq("t2_rdy1", in_ready, 1'b1);
    @(negedge clk);
    check_eq("t2_v0", out_valid, 1'b1);
    check_eq("t2_out0", out, 8'h7F);
    drive(OP_ADD, 5'd1, 5'd2, 5'd3, 8'h00);
    check_eq("t2_rdy2", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t2_v1", out_valid, 1'b1);
    check_eq("t2_out1", out, 8'h01);
    @(negedge clk);
    check_eq("t2_v2", out_valid, 1'b1);
    check_eq("t2_a2", a, 8'h7F);
    check_eq("t2_b2", b, 8'h01);
    check_eq("t2_out2", out, 8'h80);
    check_eq("t2_flag2", flag, 4'b1100);
    @(negedge clk);
    check_eq("t2_drain", out_valid, 1'b0);

    // 3: ALU table (r1=7F r2=01 r3=80)
    run("t3_sub",  OP_SUB, 5'd2, 5'd1, 5'd4,  8'h00, 8'h01, 8'h7F, 8'h82, 4'b0110);
    run("t3_cmp",  OP_CMP, 5'd1, 5'd1, 5'd1,  8'h00, 8'h7F, 8'h7F, 8'h00, 4'b0001);
    run("t3_r1",   OP_ADD, 5'd1, 5'd0, 5'd7,  8'h00, 8'h7F, 8'h00, 8'h7F, 4'b0000);
    run("t3_rbw",  OP_ADD, 5'd2, 5'd2, 5'd2,  8'h00, 8'h01, 8'h01, 8'h02, 4'b0000);
    run("t3_r2",   OP_ADD, 5'd2, 5'd0, 5'd9,  8'h00, 8'h02, 8'h00, 8'h02, 4'b0000);
    run("t3_addv", OP_ADD, 5'd4, 5'd4, 5'd10, 8'h00, 8'h82, 8'h82, 8'h04, 4'b1010);
    run("t3_shl",  OP_SHL, 5'd4, 5'd0, 5'd11, 8'h00, 8'h82, 8'h00, 8'h04, 4'b0010);
    run("t3_shr",  OP_SHR, 5'd2, 5'd0, 5'd12, 8'h00, 8'h02, 8'h00, 8'h01, 4'b0000);
    run("t3_dec",  OP_DEC, 5'd0, 5'd0, 5'd13, 8'h00, 8'h00, 8'h00, 8'hFF, 4'b0110);
    run("t3_inc",  OP_INC, 5'd1, 5'd0, 5'd14, 8'h00, 8'h7F, 8'h00, 8'h80, 4'b1100);
    run("t3_not",  OP_NOT, 5'd1, 5'd0, 5'd15, 8'h00, 8'h7F, 8'h00, 8'h80, 4'b0100);
    run("t3_xor",  OP_XOR, 5'd1, 5'd4, 5'd16, 8'h00, 8'h7F, 8'h82, 8'hFD, 4'b0100);
    run("t3_and",  OP_AND, 5'd1, 5'd4, 5'd16, 8'h00, 8'h7F, 8'h82, 8'h02, 4'b0000);
    run("t3_or",   OP_OR,  5'd1, 5'd4, 5'd16, 8'h00, 8'h7F, 8'h82, 8'hFF, 4'b0100);
    run("t3_nop",  OP_NOP, 5'd1, 5'd4, 5'd16, 8'h00, 8'h7F, 8'h82, 8'h00, 4'b0100);
    run("t3_r16",  OP_ADD, 5'd16, 5'd0, 5'd16, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'b0100);

    // 4: output backpressure with two instructions in flight
    @(negedge clk);
    out_ready = 1'b0;
    drive(OP_LDI, 5'd0, 5'd0, 5'd17, 8'h55);
    check_eq("t4_rdy0", in_ready, 1'b1);
    @(negedge clk);
    drive(OP_LDI, 5'd0, 5'd0, 5'd18, 8'hAA);
    check_eq("t4_rdy1", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t4_v0", out_valid, 1'b1);
    check_eq("t4_out0", out, 8'h55);
    check_eq("t4_full0", in_ready, 1'b0);
    @(negedge clk);
    check_eq("t4_hold_out", out, 8'h55);
    check_eq("t4_hold_flag", flag, 4'b0000);
    check_eq("t4_full1", in_ready, 1'b0);
    @(negedge clk);
    check_eq("t4_hold_out2", out, 8'h55);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_v1", out_valid, 1'b1);
    check_eq("t4_out1", out, 8'hAA);
    check_eq("t4_flag1", flag, 4'b0100);
    @(negedge clk);
    check_eq("t4_drain", out_valid, 1'b0);

    // 5: multiply (or NOP when the multiplier is not built)
    run("t5_ld1", OP_LDI, 5'd0, 5'd0, 5'd1, 8'h10, 8'h00, 8'h00, 8'h10, 4'b0000);
    run("t5_ld2", OP_LDI, 5'd0, 5'd0, 5'd2, 8'h11, 8'h00, 8'h00, 8'h11, 4'b0000);
    run("t5_cmp", OP_CMP, 5'd1, 5'd2, 5'd0, 8'h00, 8'h10, 8'h11, 8'hFF, 4'b0110);
`ifdef EXEC_UNIT_MUL_EN
    @(negedge clk);
    drive(OP_MUL, 5'd1, 5'd2, 5'd5, 8'h00);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq($sformatf("t5_wait_v%0d", i), out_valid, 1'b0);
      if (i < 8) check_eq($sformatf("t5_wait_rdy%0d", i), in_ready, 1'b0);
    end
    @(negedge clk);
    check_eq("t5_mul_v", out_valid, 1'b1);
    check_eq("t5_mul_a", a, 8'h10);
    check_eq("t5_mul_b", b, 8'h11);
    check_eq("t5_mul_out", out, 8'h10);
    check_eq("t5_mul_flag", flag, 4'b0010);
    run("t5_r5", OP_ADD, 5'd5, 5'd0, 5'd19, 8'h00, 8'h10, 8'h00, 8'h10, 4'b0000);
`else
    run("t5_mulnop", OP_MUL, 5'd1, 5'd2, 5'd5, 8'h00, 8'h10, 8'h11, 8'h00, 4'b0110);
    run("t5_r5", OP_ADD, 5'd5, 5'd0, 5'd19, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
`endif

    // 6: asynchronous reset while an instruction is pending
    @(negedge clk);
    out_ready = 1'b0;
    drive(OP_LDI, 5'd0, 5'd0, 5'd20, 8'h33);
    @(negedge clk);
    drive(OP_MUL, 5'd1, 5'd2, 5'd21, 8'h00);
    check_eq("t6_rdy", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t6_pre_out", out, 8'h33);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_pre_v", out_valid, 1'b1);
    check_eq("t6_pre_stall", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_v", out_valid, 1'b0);
    check_eq("t6_rst_out", out, 8'h00);
    check_eq("t6_rst_flag", flag, 4'b0000);
    check_eq("t6_rst_a", a, 8'h00);
    check_eq("t6_rst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t6_no_stale", out_valid, 1'b0);
    run("t6_add", OP_ADD, 5'd1, 5'd2, 5'd6, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
